// File: rtl/sw_reader_pkg.sv
// Shared types and constants for the switch debounce reader.
//   grade_t  : grade class decoded from the low switch nibble
//   state_t  : debouncer FSM states
//   NOTA_*   : unsigned grade thresholds
//   LETRA_*  : seven-segment letter patterns for downstream encoders
package sw_reader_pkg;

  typedef enum logic [1:0] {
    GRADE_P = 2'd0,
    GRADE_F = 2'd1,
    GRADE_A = 2'd2
  } grade_t;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  localparam int unsigned NOTA_A_MIN = 7;
  localparam int unsigned NOTA_F_MIN = 4;

  localparam logic [7:0] LETRA_A = 8'b01110111;
  localparam logic [7:0] LETRA_F = 8'b01110001;
  localparam logic [7:0] LETRA_P = 8'b01110011;

  // Map a grade value onto its class; thresholds are inclusive.
  function automatic grade_t grade_of(input int unsigned nota);
    if (nota >= NOTA_A_MIN)      return GRADE_A;
    else if (nota >= NOTA_F_MIN) return GRADE_F;
    else                         return GRADE_P;
  endfunction

endpackage

// File: rtl/sw_debounce_reader_if.sv
// Bundle between the raw switch bank and the display/LED consumers.
//   SWI        : raw asynchronous switch inputs
//   sw_stable  : debounced switch word
//   sw_changed : one-cycle pulse when sw_stable takes a new value
//   nota       : low nibble of sw_stable
//   grade      : grade class of nota
//   sw_rise    : bits that went 0->1 at a commit
//   sw_fall    : bits that went 1->0 at a commit
// slave is the reader side, master is the board/consumer side.
interface sw_debounce_reader_if #(
  parameter int unsigned NBITS_SW   = 8,
  parameter int unsigned NBITS_NOTA = 4
);
  import sw_reader_pkg::*;

  logic [NBITS_SW-1:0]   SWI;
  logic [NBITS_SW-1:0]   sw_stable;
  logic                  sw_changed;
  logic [NBITS_NOTA-1:0] nota;
  grade_t                grade;
  logic [NBITS_SW-1:0]   sw_rise;
  logic [NBITS_SW-1:0]   sw_fall;

  modport master (
    output SWI,
    input  sw_stable, sw_changed, nota, grade, sw_rise, sw_fall
  );

  modport slave (
    input  SWI,
    output sw_stable, sw_changed, nota, grade, sw_rise, sw_fall
  );

endinterface

// File: rtl/sw_sync2.sv
// Two-flop synchronizer for a bank of asynchronous switch inputs.
//   clk_2 : clock
//   reset : synchronous active-high reset
//   d     : asynchronous input word
//   q     : synchronized word (second flop)
module sw_sync2 #(
  parameter int unsigned NBITS_SW = 8
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [NBITS_SW-1:0] d,
  output logic [NBITS_SW-1:0] q
);

  logic [NBITS_SW-1:0] sync1;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/sw_debounce_reader.sv
// Reads the raw switch bank, synchronizes and debounces it, and publishes a
// registered switch word with a change strobe and a decoded grade class.
//   clk_2 : clock
//   reset : synchronous active-high reset
//   bus   : sw_debounce_reader_if.slave (SWI in; sw_stable, sw_changed,
//           nota, grade, sw_rise, sw_fall out)
// Optional build macro SW_EDGE_MASK_EN: registers per-bit rise/fall masks at
// each commit. Without it sw_rise/sw_fall are driven to zero.
module sw_debounce_reader
  import sw_reader_pkg::*;
#(
  parameter int unsigned NBITS_SW        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NBITS_NOTA      = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  sw_debounce_reader_if.slave   bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t              state, state_nxt;
  logic [NBITS_SW-1:0] sync2;
  logic [NBITS_SW-1:0] cand, cand_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NBITS_SW-1:0] sw_stable, stable_nxt;
  logic                sw_changed, changed_nxt;

  sw_sync2 #(.NBITS_SW(NBITS_SW)) u_sync (
    .clk_2 (clk_2),
    .reset (reset),
    .d     (bus.SWI),
    .q     (sync2)
  );

`ifdef SW_EDGE_MASK_EN
  logic [NBITS_SW-1:0] sw_rise, rise_nxt;
  logic [NBITS_SW-1:0] sw_fall, fall_nxt;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state      <= ST_STABLE;
      cand       <= '0;
      cnt        <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
`ifdef SW_EDGE_MASK_EN
      sw_rise    <= '0;
      sw_fall    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      sw_stable  <= stable_nxt;
      sw_changed <= changed_nxt;
`ifdef SW_EDGE_MASK_EN
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
`endif
    end
  end

  // Next-state and commit logic; any bit difference restarts settling.
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    stable_nxt  = sw_stable;
    changed_nxt = 1'b0;
`ifdef SW_EDGE_MASK_EN
    rise_nxt    = '0;
    fall_nxt    = '0;
`endif
    case (state)
      ST_STABLE: begin
        if (sync2 != sw_stable) begin
          state_nxt = ST_SETTLING;
          cand_nxt  = sync2;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLING: begin
        if (sync2 != cand) begin
          cand_nxt = sync2;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          // A bounce that settles back on the old word commits silently.
          state_nxt   = ST_STABLE;
          cnt_nxt     = '0;
          stable_nxt  = cand;
          changed_nxt = (cand != sw_stable);
`ifdef SW_EDGE_MASK_EN
          rise_nxt    = cand & ~sw_stable;
          fall_nxt    = ~cand & sw_stable;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end

  assign bus.sw_stable  = sw_stable;
  assign bus.sw_changed = sw_changed;
  assign bus.nota       = sw_stable[NBITS_NOTA-1:0];
  assign bus.grade      = grade_of(32'(sw_stable[NBITS_NOTA-1:0]));

`ifdef SW_EDGE_MASK_EN
  assign bus.sw_rise = sw_rise;
  assign bus.sw_fall = sw_fall;
`else
  assign bus.sw_rise = '0;
  assign bus.sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce_reader.sv
// Bench for sw_debounce_reader: hand-derived cycle table, hand-written
// reset/edge-mask sequences, and randomized switch activity checked against
// a run-length reference model of the debouncer.
module tb_sw_debounce_reader;

  localparam int unsigned NSW = 8;
  localparam int unsigned DC  = 4;
  localparam int unsigned NN  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sw_debounce_reader_if #(.NBITS_SW(NSW), .NBITS_NOTA(NN)) bus ();

  sw_debounce_reader #(
    .NBITS_SW        (NSW),
    .DEBOUNCE_CYCLES (DC),
    .NBITS_NOTA      (NN)
  ) dut (
    .clk_2 (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a two-deep input delay, then a watch window that
  // commits once the same sampled word is seen DC+1 times in a row.
  logic [NSW-1:0] m_d1, m_d2, m_stable, m_val, m_rise, m_fall;
  bit             m_changed, m_watch;
  int             m_run;

  function automatic logic [1:0] grade_ref(input logic [NSW-1:0] w);
    int n;
    n = int'(w) % 16;
    if (n >= 7)      return 2'd2;
    else if (n >= 4) return 2'd1;
    else             return 2'd0;
  endfunction

  task automatic model_edge(input logic [NSW-1:0] swi, input bit rst);
    logic [NSW-1:0] s;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_val = '0;
      m_rise = '0; m_fall = '0; m_changed = 0; m_watch = 0; m_run = 0;
      return;
    end
    s = m_d2;
    m_changed = 0;
    m_rise    = '0;
    m_fall    = '0;
    if (!m_watch) begin
      if (s != m_stable) begin
        m_watch = 1;
        m_val   = s;
        m_run   = 1;
      end
    end else begin
      if (s == m_val) m_run++;
      else begin
        m_val = s;
        m_run = 1;
      end
      if (m_run == int'(DC) + 1) begin
        m_changed = (m_val != m_stable);
        m_rise    = m_val & ~m_stable;
        m_fall    = ~m_val & m_stable;
        m_stable  = m_val;
        m_watch   = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = swi;
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1ns later.
  task automatic step(input logic [NSW-1:0] swi, input bit rst);
    logic [NSW-1:0] er, ef;
    @(negedge clk);
    bus.SWI = swi;
    reset   = rst;
    @(posedge clk);
    model_edge(swi, rst);
    #1;
`ifdef SW_EDGE_MASK_EN
    er = m_rise;
    ef = m_fall;
`else
    er = '0;
    ef = '0;
`endif
    check("mdl_stable",  32'(bus.sw_stable),  32'(m_stable));
    check("mdl_changed", 32'(bus.sw_changed), 32'(m_changed));
    check("mdl_nota",    32'(bus.nota),       32'(m_stable[NN-1:0]));
    check("mdl_grade",   32'(bus.grade),      32'(grade_ref(m_stable)));
    check("mdl_rise",    32'(bus.sw_rise),    32'(er));
    check("mdl_fall",    32'(bus.sw_fall),    32'(ef));
  endtask

  typedef struct {
    logic [NSW-1:0] swi;
    bit             rst;
    logic [NSW-1:0] st;
    bit             ch;
    logic [1:0]     gr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NSW-1:0] swi, input bit rst,
                     input logic [NSW-1:0] st, input bit ch, input logic [1:0] gr, input int n);
    vec_t v;
    v.swi = swi; v.rst = rst; v.st = st; v.ch = ch; v.gr = gr;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [NSW-1:0] cur;
    bus.SWI = '0;

    // Cycle-by-cycle expectations derived by hand (P=0, F=1, A=2).
    add(8'h00, 1, 8'h00, 0, 2'd0, 1);
    add(8'h00, 0, 8'h00, 0, 2'd0, 4);
    add(8'h05, 0, 8'h00, 0, 2'd0, 2);   // short glitch never commits
    add(8'h00, 0, 8'h00, 0, 2'd0, 8);
    add(8'h07, 0, 8'h00, 0, 2'd0, 6);   // E0..E5
    add(8'h07, 0, 8'h07, 1, 2'd2, 1);   // E6 commit
    add(8'h07, 0, 8'h07, 0, 2'd2, 3);
    add(8'h05, 0, 8'h07, 0, 2'd2, 2);   // bounce back to old value
    add(8'h07, 0, 8'h07, 0, 2'd2, 8);
    add(8'h04, 0, 8'h07, 0, 2'd2, 2);   // 04 -> 06 -> 04 bounce
    add(8'h06, 0, 8'h07, 0, 2'd2, 2);
    add(8'h04, 0, 8'h07, 0, 2'd2, 6);
    add(8'h04, 0, 8'h04, 1, 2'd1, 1);   // 6 edges after final change
    add(8'h04, 0, 8'h04, 0, 2'd1, 2);

    foreach (vecs[i]) begin
      step(vecs[i].swi, vecs[i].rst);
      check("tbl_stable",  32'(bus.sw_stable),  32'(vecs[i].st));
      check("tbl_changed", 32'(bus.sw_changed), 32'(vecs[i].ch));
      check("tbl_grade",   32'(bus.grade),      32'(vecs[i].gr));
    end

    // Reset mid-settling aborts the commit; full latency after reset.
    for (int i = 0; i < 3; i++) begin
      step(8'hA3, 0);
      check("rst_pre_changed", 32'(bus.sw_changed), 32'd0);
      check("rst_pre_stable",  32'(bus.sw_stable),  32'h04);
    end
    step(8'hA3, 1);
    check("rst_stable",  32'(bus.sw_stable),  32'h00);
    check("rst_changed", 32'(bus.sw_changed), 32'd0);
    check("rst_grade",   32'(bus.grade),      32'd0);
    for (int i = 0; i < 6; i++) begin
      step(8'hA3, 0);
      check("rst_post_changed", 32'(bus.sw_changed), 32'd0);
    end
    step(8'hA3, 0);
    check("rst_commit_stable",  32'(bus.sw_stable),  32'hA3);
    check("rst_commit_changed", 32'(bus.sw_changed), 32'd1);
    check("rst_commit_grade",   32'(bus.grade),      32'd0);

    // 0F -> F0 commit exercises every bit of the edge masks.
    for (int i = 0; i < 7; i++) step(8'h0F, 0);
    check("mask_setup_stable", 32'(bus.sw_stable), 32'h0F);
    for (int i = 0; i < 7; i++) step(8'hF0, 0);
    check("mask_stable",  32'(bus.sw_stable),  32'hF0);
    check("mask_changed", 32'(bus.sw_changed), 32'd1);
`ifdef SW_EDGE_MASK_EN
    check("mask_rise", 32'(bus.sw_rise), 32'hF0);
    check("mask_fall", 32'(bus.sw_fall), 32'h0F);
`else
    check("mask_rise", 32'(bus.sw_rise), 32'h00);
    check("mask_fall", 32'(bus.sw_fall), 32'h00);
`endif
    step(8'hF0, 0);
    check("mask_after_rise",    32'(bus.sw_rise),    32'h00);
    check("mask_after_fall",    32'(bus.sw_fall),    32'h00);
    check("mask_after_changed", 32'(bus.sw_changed), 32'd0);

    // Random switch activity: mostly holds, some bursts, rare resets.
    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 6) == 0) cur = NSW'($urandom_range(0, 255));
      else if ($urandom_range(0, 9) == 0) cur = cur ^ NSW'(1 << $urandom_range(0, 7));
      step(cur, ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_debounce_reader.md
Name: sw_debounce_reader

Overview:
- Input-side counterpart of the switch-to-display path: reads the raw SWI bank and produces a clean, debounced, registered switch word.
- Produces a one-cycle change strobe and a decoded grade class (A/F/P) from the low nibble.
- Downstream display and LCD logic consume its outputs instead of raw SWI.
- Sits between the board switches and the top-level display/LED logic in the clk_2 domain.

Parameters:
- NBITS_SW, 8, switch bank width.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to commit; legal range ≥2.
- NBITS_NOTA, 4, width of the grade field taken from sw_stable[NBITS_NOTA-1:0].

Ports:
- clk_2  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- SWI  input  NBITS_SW  raw asynchronous switch inputs.
- sw_stable  output  NBITS_SW  debounced switch word.
- sw_changed  output  1  one-cycle pulse when sw_stable takes a new value.
- nota  output  NBITS_NOTA  sw_stable[NBITS_NOTA-1:0].
- grade  output  2  grade_t: GRADE_P=0, GRADE_F=1, GRADE_A=2.
- sw_rise  output  NBITS_SW  bits that went 0→1 at the commit (optional feature).
- sw_fall  output  NBITS_SW  bits that went 1→0 at the commit (optional feature).

Behaviour:
- Interface: one clock, clk_2; reset is synchronous and active-high, named reset. All state updates on the rising edge of clk_2.
- Synchronizer: 2-flop chain sync1←SWI, sync2←sync1. Only sync2 is used downstream.
- FSM states:
  - ST_STABLE:
    - sync2==sw_stable → stay.
    - sync2!=sw_stable → ST_SETTLING, with cand←sync2 and cnt←0.
  - ST_SETTLING:
    - sync2!=cand → cand←sync2, cnt←0, stay. The restart applies on any bit difference.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 → commit and go to ST_STABLE.
    - Otherwise cnt←cnt+1.
- Commit:
  - sw_stable←cand.
  - sw_changed←1 only if cand!=sw_stable, else 0. This covers a bounce that settles back to the old value: return to ST_STABLE with no pulse.
- sw_changed is high for exactly one cycle per commit and 0 otherwise.
- Latency: let E0 be the first rising edge after SWI changes and then holds. sw_stable and sw_changed update on edge E(DEBOUNCE_CYCLES+2); that is edge E6 at default.
- Glitches: a change that reverts within fewer than DEBOUNCE_CYCLES sync2 samples never reaches sw_stable.
- cnt width: $clog2(DEBOUNCE_CYCLES). The counter never wraps; it is cleared on commit and on restart.
- grade:
  - Combinational from nota.
  - nota≥7 → GRADE_A; nota≥4 → GRADE_F; otherwise GRADE_P. Comparisons are unsigned.
  - grade changes in the same cycle as sw_stable.
- Reset values:
  - sync1, sync2, cand, cnt, sw_stable, sw_changed, sw_rise, sw_fall = 0.
  - State = ST_STABLE; nota = 0; grade = GRADE_P.
- Reset mid-settling: aborts the pending commit with no sw_changed pulse. Afterward, SWI≠0 is re-detected through the full latency.
- Reset has priority over every other event in the same cycle.

Optional Feature:
- SW_EDGE_MASK_EN defined:
  - At a commit, sw_rise←cand & ~sw_stable_old and sw_fall←~cand & sw_stable_old.
  - Both are one-cycle, aligned with sw_changed, and 0 otherwise.
- Undefined: sw_rise and sw_fall are tied to 0 and no extra registers are generated. The ports remain.

Decomposition:
- Package sw_reader_pkg:
  - grade_t enum.
  - state_t enum {ST_STABLE, ST_SETTLING}.
  - Grade thresholds NOTA_A_MIN=7 and NOTA_F_MIN=4.
  - Seven-segment letter constants LETRA_A=8'b01110111, LETRA_F=8'b01110001, LETRA_P=8'b01110011 for downstream encoders.
- Sub-module sw_sync2: parameterised NBITS_SW-wide 2-flop synchronizer with synchronous reset, instantiated once.

Test Plan:
- Reset, then SWI=8'h00 held → sw_stable=0, grade=GRADE_P, sw_changed never asserted.
- SWI 00→8'h07 at E0, held → sw_stable=07, grade=GRADE_A, sw_changed=1 only on E6.
- SWI toggles 00→05→00 with 2 cycles at 05 (DEBOUNCE_CYCLES=4) → sw_stable stays 00, no pulse.
- SWI bounces 00→04→06→04 every 2 cycles, then holds 04 → single commit to 04, grade=GRADE_F, exactly one pulse 6 edges after the final change.
- SWI 00→8'hA3 then reset asserted 3 cycles later for one cycle → no pulse during settling; after reset, sw_stable=A3 is committed with one pulse.
- With SW_EDGE_MASK_EN: sw_stable 8'h0F→8'hF0 → sw_rise=F0, sw_fall=0F for one cycle, both 0 after.
